// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the priority interrupt controller: register map,
// handshake FSM states and VEC register layout.
package intr_ctrl_pkg;

    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_VEC  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int VEC_VALID_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder: source 0 has the highest priority.
module intr_prio_enc #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic [NSRC-1:0] req,
    output logic [IDW-1:0]  id,
    output logic            any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) id = IDW'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/intr_ctrl.sv
// Priority interrupt controller: edge-captured pending requests, mask/enable
// registers, and a REQ/ACK handshake with the CPU's intr/inta lines.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [NSRC-1:0] irq,
    input  logic            inta,
    output logic            intr,
    input  logic            sel,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);

    state_e          state_q, state_d;
    logic [NSRC-1:0] irq_q, irq_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            en_q, en_d;
    logic            vec_valid_q, vec_valid_d;
    logic [IDW-1:0]  vec_id_q, vec_id_d;
    logic            intr_q, intr_d;

    logic [NSRC-1:0] rise;
    logic [IDW-1:0]  win_id;
    logic            win_any;
    logic            req;
    logic            wr;
    logic            ack;
    logic            unused_wdata;

    assign unused_wdata = ^wdata;

    intr_prio_enc #(
        .NSRC(NSRC),
        .IDW (IDW)
    ) u_prio_enc (
        .req(pend_q & mask_q),
        .id (win_id),
        .any(win_any)
    );

    assign rise = irq & ~irq_q;
    assign req  = en_q & win_any;
    assign wr   = sel & we;

    always_comb begin
        state_d     = state_q;
        ack         = 1'b0;
        irq_d       = irq;
        pend_d      = pend_q;
        mask_d      = mask_q;
        en_d        = en_q;
        vec_valid_d = vec_valid_q;
        vec_id_d    = vec_id_q;

        // An ack is only honoured while a live winner exists, so VEC never records a stale id.
        case (state_q)
            ST_IDLE: if (req) state_d = ST_REQ;
            ST_REQ: begin
                if (inta && req) begin
                    state_d = ST_ACK;
                    ack     = 1'b1;
                end else if (!req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (wr && addr == ADDR_PEND) pend_d = pend_d & ~wdata[NSRC-1:0];
        if (ack) begin
            pend_d[win_id] = 1'b0;
            vec_valid_d    = 1'b1;
            vec_id_d       = win_id;
        end
        // New edges are applied last so a same-cycle rise survives any clear.
        pend_d = pend_d | rise;

        if (wr && addr == ADDR_MASK) mask_d = wdata[NSRC-1:0];
        if (wr && addr == ADDR_CTRL) en_d = wdata[0];

        intr_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= ST_IDLE;
            irq_q       <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            en_q        <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_id_q    <= '0;
            intr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            en_q        <= en_d;
            vec_valid_q <= vec_valid_d;
            vec_id_q    <= vec_id_d;
            intr_q      <= intr_d;
        end
    end

    assign intr = intr_q;

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                ADDR_PEND: rdata[NSRC-1:0] = pend_q;
                ADDR_MASK: rdata[NSRC-1:0] = mask_q;
                ADDR_VEC: begin
                    rdata[VEC_VALID_BIT] = vec_valid_q;
                    rdata[IDW-1:0]       = vec_id_q;
                end
                ADDR_CTRL: rdata[0] = en_q;
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios followed by random traffic, all
// compared against a register-level behavioural model of the controller.
module tb_intr_ctrl;

    localparam int NSRC = 8;
    localparam int IDW  = 3;

    logic            clk = 1'b0;
    logic            clrn;
    logic [NSRC-1:0] irq;
    logic            inta;
    logic            intr;
    logic            sel;
    logic            we;
    logic [1:0]      addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: what software and the CPU should observe.
    logic [NSRC-1:0] m_pend, m_mask, m_irq_prev;
    logic            m_en, m_vec_valid, m_intr, m_cool;
    int              m_vec_id;

    intr_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
        .clk  (clk),
        .clrn (clrn),
        .irq  (irq),
        .inta (inta),
        .intr (intr),
        .sel  (sel),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: r = 32'(m_pend);
            2'd1: r = 32'(m_mask);
            2'd2: r = m_vec_valid ? (32'h8000_0000 + 32'(m_vec_id)) : 32'(m_vec_id);
            default: r = {31'd0, m_en};
        endcase
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [NSRC-1:0] pm, np;
        bit rq, ak;
        int w;
        if (!clrn) begin
            m_pend = '0; m_mask = '0; m_irq_prev = '0; m_en = 0;
            m_vec_valid = 0; m_vec_id = 0; m_intr = 0; m_cool = 0;
            return;
        end
        pm = m_pend & m_mask;
        rq = m_en && (pm != 0);
        w  = 0;
        for (int i = NSRC - 1; i >= 0; i--) if (pm[i]) w = i;
        ak = m_intr && inta && rq;
        np = m_pend;
        if (sel && we && addr == 2'd0) np = np & ~wdata[NSRC-1:0];
        if (ak) begin
            np[w] = 1'b0;
            m_vec_valid = 1;
            m_vec_id = w;
        end
        np = np | (irq & ~m_irq_prev);
        if (sel && we && addr == 2'd1) m_mask = wdata[NSRC-1:0];
        if (sel && we && addr == 2'd3) m_en = wdata[0];
        if (m_intr) begin
            m_cool = ak;
            m_intr = !ak && rq;
        end else if (m_cool) begin
            m_cool = 0;
        end else begin
            m_intr = rq;
        end
        m_pend = np;
        m_irq_prev = irq;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("intr", {31'd0, intr}, {31'd0, m_intr});
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        sel = 1; we = 1; addr = a; wdata = d;
        tick();
        sel = 0; we = 0; wdata = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        sel = 1; we = 0; addr = a;
        #1;
        chk(tag, rdata, exp);
        sel = 0;
    endtask

    task automatic rd_all_model();
        for (int a = 0; a < 4; a++) rd_chk("reg_vs_model", 2'(a), model_rd(2'(a)));
    endtask

    initial begin
        clrn = 0; irq = 0; inta = 0; sel = 0; we = 0; addr = 0; wdata = 0;
        m_pend = '0; m_mask = '0; m_irq_prev = '0; m_en = 0;
        m_vec_valid = 0; m_vec_id = 0; m_intr = 0; m_cool = 0;
        tick();
        tick();
        clrn = 1;
        chk("reset_intr", {31'd0, intr}, 32'd0);
        rd_chk("reset_pend", 2'd0, 32'd0);
        rd_chk("reset_mask", 2'd1, 32'd0);
        rd_chk("reset_vec",  2'd2, 32'd0);
        rd_chk("reset_ctrl", 2'd3, 32'd0);
        chk("rdata_unsel", rdata, 32'd0);

        // Single source, two-edge latency, ack clears pending.
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd1, 32'h04);
        irq = 8'h04; tick();
        chk("t1_intr_early", {31'd0, intr}, 32'd0);
        irq = 8'h00; tick();
        chk("t1_intr_up", {31'd0, intr}, 32'd1);
        inta = 1; tick(); inta = 0;
        chk("t1_intr_ack", {31'd0, intr}, 32'd0);
        rd_chk("t1_vec",  2'd2, 32'h8000_0002);
        rd_chk("t1_pend", 2'd0, 32'd0);

        // Two simultaneous sources served in priority order.
        wr_reg(2'd1, 32'hFF);
        irq = 8'h22; tick();
        irq = 8'h00; tick();
        chk("t2_intr_up", {31'd0, intr}, 32'd1);
        inta = 1; tick(); inta = 0;
        rd_chk("t2_vec1", 2'd2, 32'h8000_0001);
        rd_chk("t2_pend1", 2'd0, 32'h20);
        tick();
        chk("t2_intr_gap", {31'd0, intr}, 32'd0);
        tick();
        chk("t2_intr_again", {31'd0, intr}, 32'd1);
        inta = 1; tick(); inta = 0;
        rd_chk("t2_vec2", 2'd2, 32'h8000_0005);
        tick();

        // Masked source, unmask raises, disable withdraws.
        wr_reg(2'd1, 32'h00);
        irq = 8'h08; tick();
        irq = 8'h00; tick(); tick();
        chk("t3_masked", {31'd0, intr}, 32'd0);
        wr_reg(2'd1, 32'h08);
        tick();
        chk("t3_unmask", {31'd0, intr}, 32'd1);
        wr_reg(2'd3, 32'd0);
        tick();
        chk("t3_disable", {31'd0, intr}, 32'd0);
        rd_chk("t3_pend", 2'd0, 32'h08);

        // W1C colliding with a new rise: set wins; a plain W1C clears.
        irq = 8'h08; sel = 1; we = 1; addr = 2'd0; wdata = 32'h08;
        tick();
        sel = 0; we = 0; wdata = 0; irq = 8'h00;
        rd_chk("t4_set_wins", 2'd0, 32'h08);
        tick();
        wr_reg(2'd0, 32'h08);
        rd_chk("t4_w1c", 2'd0, 32'h00);

        // inta while idle has no effect.
        irq = 8'h40; tick(); irq = 8'h00; tick();
        inta = 1; tick(); inta = 0;
        rd_chk("t5_vec",  2'd2, 32'h8000_0005);
        rd_chk("t5_pend", 2'd0, 32'h40);

        // Reset while requesting.
        wr_reg(2'd1, 32'hFF);
        wr_reg(2'd3, 32'd1);
        tick();
        chk("t6_intr_up", {31'd0, intr}, 32'd1);
        clrn = 0; tick(); clrn = 1;
        chk("t6_intr", {31'd0, intr}, 32'd0);
        rd_chk("t6_pend", 2'd0, 32'd0);
        rd_chk("t6_mask", 2'd1, 32'd0);
        rd_chk("t6_vec",  2'd2, 32'd0);
        rd_chk("t6_ctrl", 2'd3, 32'd0);

        // Random traffic against the model.
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd1, 32'hFF);
        for (int c = 0; c < 600; c++) begin
            irq  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            inta = (m_intr && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) begin
                sel = 1; we = 1;
                addr = 2'($urandom_range(0, 3));
                wdata = (addr == 2'd3) ? 32'($urandom_range(0, 7) != 0) : $urandom;
            end
            if ($urandom_range(0, 199) == 0) clrn = 0;
            tick();
            sel = 0; we = 0; wdata = 0; inta = 0; clrn = 1;
            if (c % 8 == 0) rd_all_model();
        end
        irq = 0;
        tick();
        rd_all_model();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
